// File: rtl/nonce_collector_fifo.sv
// nonce_collector_fifo
//   Collects golden nonces from SLAVES sources into per-source capture slots,
//   arbitrates them round-robin into a small FIFO and drains the FIFO one word
//   at a time into a serial transmitter through a start/busy handshake.
//
// Ports
//   hash_clk      in   1                 sole clock, rising edge
//   reset_n       in   1                 async active-low reset
//   new_nonces    in   SLAVES            1-cycle hit strobe per slave
//   slave_nonces  in   SLAVES*NONCE_W    slave i nonce at [i*NONCE_W +: NONCE_W]
//   flush         in   1                 sync clear of slots, FIFO and rr pointer
//   serial_busy   in   1                 transmitter busy
//   serial_send   out  1                 1-cycle start strobe to transmitter
//   golden_nonce  out  NONCE_W           word being / last sent
//   golden_slave  out  ID_W              source slave of golden_nonce
//   fifo_level    out  FIFO_LOG2+1       entries in FIFO
//   drop_count    out  16                saturating count of lost nonces
module nonce_collector_fifo #(
   parameter int SLAVES    = 11,
   parameter int NONCE_W   = 32,
   parameter int FIFO_LOG2 = 3,
   parameter int ID_W      = 4
) (
   input  logic                        hash_clk,
   input  logic                        reset_n,
   input  logic [SLAVES-1:0]           new_nonces,
   input  logic [SLAVES*NONCE_W-1:0]   slave_nonces,
   input  logic                        flush,
   input  logic                        serial_busy,
   output logic                        serial_send,
   output logic [NONCE_W-1:0]          golden_nonce,
   output logic [ID_W-1:0]             golden_slave,
   output logic [FIFO_LOG2:0]          fifo_level,
   output logic [15:0]                 drop_count
);

   localparam int DEPTH   = 1 << FIFO_LOG2;
   localparam int ENTRY_W = ID_W + NONCE_W;
   localparam int CNT_W   = $clog2(SLAVES + 1);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT} state_t;

   // ---------------- capture slots ----------------
   logic [SLAVES-1:0]  pending_vec;
   logic [SLAVES-1:0]  drop_hit;
   logic [NONCE_W-1:0] slot_nonce [SLAVES];

   logic               grant_valid;
   logic [ID_W-1:0]    grant_idx;
   logic [NONCE_W-1:0] grant_nonce;

   genvar gi;
   generate
      for (gi = 0; gi < SLAVES; gi++) begin : g_slot
         logic               pending_reg;
         logic [NONCE_W-1:0] nonce_reg;
         logic               granted;

         assign granted = grant_valid && (grant_idx == ID_W'(gi));

         // A hit on a slot that is being granted this cycle replaces the
         // outgoing value, so the slot stays pending with the new nonce.
         always_ff @(posedge hash_clk or negedge reset_n) begin
            if (!reset_n) begin
               pending_reg <= 1'b0;
               nonce_reg   <= '0;
            end else if (flush) begin
               pending_reg <= 1'b0;
            end else if (new_nonces[gi] && (!pending_reg || granted)) begin
               pending_reg <= 1'b1;
               nonce_reg   <= slave_nonces[gi*NONCE_W +: NONCE_W];
            end else if (granted) begin
               pending_reg <= 1'b0;
            end
         end

         assign pending_vec[gi] = pending_reg;
         assign slot_nonce[gi]  = nonce_reg;
         assign drop_hit[gi]    = new_nonces[gi] && pending_reg && !granted && !flush;
      end
   endgenerate

   // ---------------- round-robin arbiter ----------------
   logic [ID_W-1:0]      rr_ptr_reg;
   logic                 full_reg;
   logic [FIFO_LOG2:0]   wr_ptr_reg, rd_ptr_reg;

   always_comb begin
      int idx;
      grant_valid = 1'b0;
      grant_idx   = '0;
      grant_nonce = '0;
      idx         = 0;
      for (int k = 0; k < SLAVES; k++) begin
         idx = int'(rr_ptr_reg) + k;
         if (idx >= SLAVES) idx = idx - SLAVES;
         if (!grant_valid && pending_vec[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = ID_W'(idx);
            grant_nonce = slot_nonce[idx];
         end
      end
      // Registered full flag only: no write-through into a full FIFO even
      // when a pop happens in the same cycle.
      if (full_reg || flush) grant_valid = 1'b0;
   end

   always_ff @(posedge hash_clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr_reg <= '0;
      end else if (flush) begin
         rr_ptr_reg <= '0;
      end else if (grant_valid) begin
         rr_ptr_reg <= (grant_idx == ID_W'(SLAVES - 1)) ? '0 : grant_idx + ID_W'(1);
      end
   end

   // ---------------- FIFO ----------------
   logic [ENTRY_W-1:0]  mem [DEPTH];
   logic                pop;
   logic                fifo_empty;
   logic [FIFO_LOG2:0]  wr_ptr_next, rd_ptr_next;

   assign fifo_empty  = (wr_ptr_reg == rd_ptr_reg);
   assign wr_ptr_next = wr_ptr_reg + (FIFO_LOG2+1)'(grant_valid);
   assign rd_ptr_next = rd_ptr_reg + (FIFO_LOG2+1)'(pop);

   always_ff @(posedge hash_clk) begin
      if (grant_valid) mem[wr_ptr_reg[FIFO_LOG2-1:0]] <= {grant_idx, grant_nonce};
   end

   always_ff @(posedge hash_clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         full_reg   <= 1'b0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         full_reg   <= 1'b0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         full_reg   <= ((wr_ptr_next - rd_ptr_next) == (FIFO_LOG2+1)'(DEPTH));
      end
   end

   assign fifo_level = wr_ptr_reg - rd_ptr_reg;

   // ---------------- drop counter ----------------
   logic [CNT_W-1:0] drop_n;
   logic [16:0]      drop_sum;
   logic [15:0]      drop_count_reg;

   always_comb begin
      drop_n = '0;
      for (int k = 0; k < SLAVES; k++) drop_n = drop_n + CNT_W'(drop_hit[k]);
      drop_sum = {1'b0, drop_count_reg} + 17'(drop_n);
   end

   always_ff @(posedge hash_clk or negedge reset_n) begin
      if (!reset_n)          drop_count_reg <= '0;
      else if (drop_sum[16]) drop_count_reg <= 16'hFFFF;
      else                   drop_count_reg <= drop_sum[15:0];
   end

   assign drop_count = drop_count_reg;

   // ---------------- TX FSM ----------------
   state_t        state_reg, state_next;
   logic [1:0]    arm_cnt_reg, arm_cnt_next;
   logic          serial_send_reg;
   logic [NONCE_W-1:0] golden_nonce_reg;
   logic [ID_W-1:0]    golden_slave_reg;

   always_comb begin
      state_next   = state_reg;
      arm_cnt_next = arm_cnt_reg;
      pop          = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (!fifo_empty && !flush) begin
               pop          = 1'b1;
               state_next   = S_ARM;
               arm_cnt_next = '0;
            end
         end
         S_ARM: begin
            // The strobe cycle is the first of four ARM cycles; if busy never
            // shows up the word is treated as sent.
            if (serial_busy)               state_next = S_WAIT;
            else if (arm_cnt_reg == 2'd3)  state_next = S_IDLE;
            else                           arm_cnt_next = arm_cnt_reg + 2'd1;
         end
         S_WAIT: begin
            if (!serial_busy) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge hash_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg        <= S_IDLE;
         arm_cnt_reg      <= '0;
         serial_send_reg  <= 1'b0;
         golden_nonce_reg <= '0;
         golden_slave_reg <= '0;
      end else begin
         state_reg       <= state_next;
         arm_cnt_reg     <= arm_cnt_next;
         serial_send_reg <= pop;
         if (pop) begin
            {golden_slave_reg, golden_nonce_reg} <= mem[rd_ptr_reg[FIFO_LOG2-1:0]];
         end
      end
   end

   assign serial_send  = serial_send_reg;
   assign golden_nonce = golden_nonce_reg;
   assign golden_slave = golden_slave_reg;

endmodule
